// File: rtl/hist_readout_rx.sv
// Receiver for the histogram readout stream: stores per-bin counts in a local register file and
// tracks the total, the peak bin and framing errors while a frame is captured.
module hist_readout_rx #(
    parameter int unsigned NUM_BINS = 16,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned SUM_W    = 12
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_i,
    input  logic [DATA_W-1:0]             data_in_i,
    input  logic                          valid_in_i,
    input  logic                          last_in_i,
    input  logic [$clog2(NUM_BINS)-1:0]   rd_addr_i,
    output logic [DATA_W-1:0]             rd_data_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          err_frame_o,
    output logic [$clog2(NUM_BINS):0]     bins_rx_o,
    output logic [SUM_W-1:0]              total_o,
    output logic [$clog2(NUM_BINS)-1:0]   peak_bin_o,
    output logic [DATA_W-1:0]             peak_count_o
);

    localparam int unsigned AW = $clog2(NUM_BINS);

    typedef enum logic [1:0] {StIdle, StArmed, StCapture, StDone} state_e;

    state_e              state_q, state_d;
    logic [AW:0]         bins_rx_q, bins_rx_d;
    logic [SUM_W-1:0]    total_q, total_d;
    logic [AW-1:0]       peak_bin_q, peak_bin_d;
    logic [DATA_W-1:0]   peak_count_q, peak_count_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rd_data_q;
    logic [DATA_W-1:0]   bins_q [NUM_BINS];

    logic          in_frame;
    logic          beat;
    logic [AW-1:0] idx;
    logic          at_end_idx;
    logic          frame_end;

    // start has priority over a beat arriving in the same cycle
    assign in_frame   = (state_q == StArmed) || (state_q == StCapture);
    assign beat       = in_frame && valid_in_i && !start_i;
    assign idx        = bins_rx_q[AW-1:0];
    assign at_end_idx = (bins_rx_q == (AW+1)'(NUM_BINS - 1));
    assign frame_end  = beat && (last_in_i || at_end_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start_i) begin
            state_d = StArmed;
        end else begin
            unique case (state_q)
                StArmed: begin
                    if (beat) state_d = frame_end ? StDone : StCapture;
                end
                StCapture: begin
                    if (frame_end) state_d = StDone;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        busy_o = in_frame;
        done_o = (state_q == StDone);
    end

    always_comb begin
        bins_rx_d    = bins_rx_q;
        total_d      = total_q;
        peak_bin_d   = peak_bin_q;
        peak_count_d = peak_count_q;
        err_d        = err_q;
        if (start_i) begin
            bins_rx_d    = '0;
            total_d      = '0;
            peak_bin_d   = '0;
            peak_count_d = '0;
            err_d        = 1'b0;
        end else if (beat) begin
            bins_rx_d = bins_rx_q + 1'b1;
            total_d   = total_q + SUM_W'(data_in_i);
            // Bin 0 always seeds the peak; later bins replace it only when strictly larger
            if ((bins_rx_q == '0) || (data_in_i > peak_count_q)) begin
                peak_count_d = data_in_i;
                peak_bin_d   = idx;
            end
            if (frame_end) err_d = !(last_in_i && at_end_idx);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bins_rx_q    <= '0;
            total_q      <= '0;
            peak_bin_q   <= '0;
            peak_count_q <= '0;
            err_q        <= 1'b0;
        end else begin
            bins_rx_q    <= bins_rx_d;
            total_q      <= total_d;
            peak_bin_q   <= peak_bin_d;
            peak_count_q <= peak_count_d;
            err_q        <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BINS; i++) bins_q[i] <= '0;
        end else if (beat) begin
            bins_q[idx] <= data_in_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= bins_q[rd_addr_i];
        end
    end

    assign rd_data_o    = rd_data_q;
    assign err_frame_o  = err_q;
    assign bins_rx_o    = bins_rx_q;
    assign total_o      = total_q;
    assign peak_bin_o   = peak_bin_q;
    assign peak_count_o = peak_count_q;

endmodule

// File: tb/tb_hist_readout_rx.sv
// Scoreboard bench for hist_readout_rx: expected frame results and read-backs are queued by the
// stimulus and checked by a monitor when done rises or read data returns.
module tb_hist_readout_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  data_in;
    logic        valid_in;
    logic        last_in;
    logic [3:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        busy;
    logic        done;
    logic        err_frame;
    logic [4:0]  bins_rx;
    logic [11:0] total;
    logic [3:0]  peak_bin;
    logic [7:0]  peak_count;

    hist_readout_rx #(
        .NUM_BINS(16),
        .DATA_W  (8),
        .SUM_W   (12)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .data_in_i   (data_in),
        .valid_in_i  (valid_in),
        .last_in_i   (last_in),
        .rd_addr_i   (rd_addr),
        .rd_data_o   (rd_data),
        .busy_o      (busy),
        .done_o      (done),
        .err_frame_o (err_frame),
        .bins_rx_o   (bins_rx),
        .total_o     (total),
        .peak_bin_o  (peak_bin),
        .peak_count_o(peak_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    err;
        int    rx;
        int    tot;
        int    pb;
        int    pc;
    } frame_t;

    frame_t frame_q[$];
    int     rd_q[$];
    int     n_pass  = 0;
    int     n_total = 0;
    bit     done_prev = 1'b0;
    bit     rd_stage  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Monitor: frame results on each rising done, read data one cycle after the address
    always @(negedge clk) begin
        frame_t f;
        if (done && !done_prev) begin
            if (frame_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done: done rose with no frame expected");
            end else begin
                f = frame_q.pop_front();
                check({f.name, "_err"},        int'(err_frame),  f.err);
                check({f.name, "_bins_rx"},    int'(bins_rx),    f.rx);
                check({f.name, "_total"},      int'(total),      f.tot);
                check({f.name, "_peak_bin"},   int'(peak_bin),   f.pb);
                check({f.name, "_peak_count"}, int'(peak_count), f.pc);
            end
        end
        done_prev = done;
        if (rd_stage) begin
            check("rd_data", int'(rd_data), rd_q.pop_front());
            rd_stage = 1'b0;
        end else if (rd_q.size() != 0) begin
            rd_stage = 1'b1;
        end
    end

    task automatic expect_frame(input string n, input int e, input int r, input int t,
                                input int b, input int c);
        frame_t f;
        f.name = n; f.err = e; f.rx = r; f.tot = t; f.pb = b; f.pc = c;
        frame_q.push_back(f);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input int d, input bit l);
        valid_in = 1'b1;
        data_in  = 8'(d);
        last_in  = l;
        @(posedge clk); #1;
        valid_in = 1'b0;
        last_in  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic read_bin(input int a, input int exp);
        rd_addr = 4'(a);
        rd_q.push_back(exp);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},       int'(busy),       0);
        check({tag, "_done"},       int'(done),       0);
        check({tag, "_err"},        int'(err_frame),  0);
        check({tag, "_bins_rx"},    int'(bins_rx),    0);
        check({tag, "_total"},      int'(total),      0);
        check({tag, "_peak_bin"},   int'(peak_bin),   0);
        check({tag, "_peak_count"}, int'(peak_count), 0);
        check({tag, "_rd_data"},    int'(rd_data),    0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; data_in = '0; valid_in = 1'b0; last_in = 1'b0;
        rd_addr = '0;
        #3;
        check_all_zero("reset");
        #10 rst_n = 1'b1;
        idle(2);

        // Nominal frame: 0..15
        pulse_start();
        check("busy_after_start", int'(busy), 1);
        expect_frame("nominal", 0, 16, 120, 15, 15);
        for (int i = 0; i < 16; i++) send(i, i == 15);
        check("nominal_busy_low", int'(busy), 0);
        read_bin(7, 7);

        // Tie at bins 4 and 9 with gaps
        pulse_start();
        expect_frame("tie", 0, 16, 442, 4, 200);
        for (int i = 0; i < 16; i++) begin
            idle($urandom_range(0, 2));
            send((i == 4 || i == 9) ? 200 : 3, i == 15);
        end
        read_bin(9, 200);

        // Short frame: last on beat 5, trailing beats ignored
        pulse_start();
        expect_frame("short", 1, 6, 60, 0, 10);
        for (int i = 0; i < 6; i++) send(10, i == 5);
        for (int i = 0; i < 3; i++) send(10, 1'b1);
        check("short_total_hold",   int'(total),   60);
        check("short_bins_rx_hold", int'(bins_rx), 6);
        check("short_done_hold",    int'(done),    1);

        // Overrun: 16 beats of 255 without last
        pulse_start();
        expect_frame("overrun", 1, 16, 4080, 0, 255);
        for (int i = 0; i < 16; i++) send(255, 1'b0);
        send(255, 1'b0);
        check("overrun_total_hold",   int'(total),   4080);
        check("overrun_bins_rx_hold", int'(bins_rx), 16);

        // Restart while beat 8 is valid
        pulse_start();
        for (int i = 0; i < 8; i++) send(50, 1'b0);
        start = 1'b1;
        send(50, 1'b0);
        start = 1'b0;
        check("restart_bins_rx", int'(bins_rx), 0);
        check("restart_total",   int'(total),   0);
        check("restart_busy",    int'(busy),    1);
        expect_frame("after_restart", 0, 16, 240, 15, 30);
        for (int i = 0; i < 16; i++) send(2 * i, i == 15);

        // Async reset mid-frame, shorter than a clock period
        pulse_start();
        for (int i = 0; i < 5; i++) send(20 + i, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        #3 rst_n = 1'b1;
        idle(1);
        for (int a = 0; a < 16; a++) read_bin(a, 0);
        pulse_start();
        expect_frame("post_reset", 1, 2, 16, 1, 9);
        send(7, 1'b0);
        send(9, 1'b1);

        idle(3);
        check("pending_frames", frame_q.size(), 0);
        check("pending_reads",  rd_q.size(),    0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hist_readout_rx.md
# hist_readout_rx

Receiver for the histogram readout stream: it captures the per-bin counts that the histogramming core emits as 8-bit beats marked by `valid` and `last_bin`. Captured bins are stored in a local register file readable by address. While capturing, the block computes the total count and the peak (mode) bin, and it flags framing errors. It sits on the consumer side of the histogram data/status pins, either as an on-chip checker or inside the FPGA-side harness.

## Interface
- `NUM_BINS`, default 16: number of bins per readout frame (power of two, ≥2).
- `DATA_W`, default 8: width of a bin count beat.
- `SUM_W`, default 12: width of the total accumulator; must satisfy `SUM_W ≥ DATA_W + log2(NUM_BINS)`.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pulse that arms a new capture.
- `data_in`  in  DATA_W  bin count beat.
- `valid_in`  in  1  `data_in` is valid this cycle.
- `last_in`  in  1  the current valid beat is the final bin of the frame.
- `rd_addr`  in  log2(NUM_BINS)  read address into the captured bins.
- `rd_data`  out  DATA_W  registered count of bin `rd_addr`.
- `busy`  out  1  the block is in ARMED or CAPTURE.
- `done`  out  1  a frame is complete and results are stable.
- `err_frame`  out  1  the last frame had a wrong length.
- `bins_rx`  out  log2(NUM_BINS)+1  number of beats stored in the current or last frame.
- `total`  out  SUM_W  sum of the stored counts.
- `peak_bin`  out  log2(NUM_BINS)  index of the largest count.
- `peak_count`  out  DATA_W  value of the largest count.

## Operation
- **Reset values.** While `rst_n` is low, all outputs are 0 and the state is IDLE. All bin registers clear to 0 asynchronously.
- **States:** IDLE, ARMED, CAPTURE, DONE.
- **IDLE to ARMED** on `start`. Entering ARMED clears `bins_rx`, `total`, `peak_bin`, `peak_count`, `err_frame` and `done`. Bin registers are not cleared.
- **ARMED to CAPTURE** on the first beat with `valid_in`=1. That beat is stored as bin 0.
- **Beat handling** (ARMED or CAPTURE, with `valid_in`=1):
  - write `data_in` to bin[`bins_rx`];
  - `bins_rx` += 1;
  - `total` += `data_in`, zero-extended with no saturation;
  - if `data_in` > `peak_count` (strictly greater), then `peak_count` ← `data_in` and `peak_bin` ← the beat index. On ties, the lowest index wins.
  - Bin 0 always loads the peak registers, so an all-zero frame gives `peak_bin`=0 and `peak_count`=0.
- **Frame end:**
  - If `last_in`=1 and the beat index is NUM_BINS−1, go to DONE with `err_frame`=0.
  - If `last_in`=1 and the beat index is less than NUM_BINS−1, go to DONE with `err_frame`=1 (short frame).
  - If the beat index is NUM_BINS−1 and `last_in`=0, store the beat, then go to DONE with `err_frame`=1 (overrun).
- **Ignored inputs:**
  - `valid_in` gaps inside a frame are allowed; cycles with `valid_in`=0 change nothing.
  - `last_in` without `valid_in` is ignored.
  - Beats that arrive in IDLE or DONE are ignored.
- **DONE.** Results hold until `start`. `start` in DONE goes to ARMED with the same clears.
- **`start` while busy.** The capture is abandoned and the block re-enters ARMED with the clears applied. A beat in that same cycle is discarded, because `start` has priority.
- **Read port.** `rd_data` ← bin[`rd_addr`] registered, in any state. Reading a bin in the same cycle it is written returns the old value.

## Timing
- **Beat results.** A beat sampled at edge N is reflected in `total`, `peak_*`, `bins_rx` and the bin register after edge N.
- **Frame completion.** `done` and `err_frame` assert after the same edge that samples the final beat, so all results are valid in that cycle. `busy` deasserts in that same cycle.
- **`start` response.** `busy`=1 from the cycle after `start` is sampled.
- **Read latency.** `rd_data` lags `rd_addr` by 1 cycle.
- **Throughput.** One beat per cycle with no back-pressure; the sender is never stalled.
- **Reset mid-frame.** An asynchronous reset mid-frame clears everything immediately, and the block restarts from IDLE on the first edge after release.

## Test plan
- **Nominal frame.** Reset, `start`, then 16 back-to-back beats with values 0..15, `last_in` on beat 15.
  - Required: `done`=1 and `err_frame`=0 after the last edge; `bins_rx`=16, `total`=120, `peak_bin`=15, `peak_count`=15.
  - Read-back: `rd_addr`=7 gives `rd_data`=7 one cycle later.
- **Tie and gaps.**
  - Stimulus: beats of 3 at every bin except 200 at bins 4 and 9, with random `valid_in` gaps.
  - Required: `peak_bin`=4, `peak_count`=200, `total`=442.
- **Short frame.** `last_in` on beat 5 (values 10 each).
  - Required: `done`=1, `err_frame`=1, `bins_rx`=6, `total`=60.
  - Beats that follow are ignored and `total` stays 60.
- **Overrun.** 16 beats of 255 with no `last_in`.
  - Required: `done`=1, `err_frame`=1 after beat 15, `total`=4080 with no wrap, and beat 16 ignored.
- **Restart.** `start` pulsed while beat 8 is valid.
  - Required: that beat is discarded and `bins_rx`=0 next cycle.
  - A following full frame completes correctly with `bins_rx`=16.
- **Async reset mid-frame.** `rst_n` low mid-frame for less than one clock period.
  - Required: all outputs 0 immediately, `rd_data` of every bin reads 0, and `start` then works normally.
